// File: rtl/ucq_rr_scheduler_if.sv
// Bus bundle between the engine array, ucq_rr_scheduler and the unit-clause arbiter.
// master: the scheduler side; slave: the engines/arbiter environment.
interface ucq_rr_scheduler_if #(
  parameter int NUM_ENG = 4,
  parameter int LIT_W   = 8,
  parameter int ID_W    = $clog2(NUM_ENG)
);
  logic [NUM_ENG*LIT_W-1:0] eng_uc;
  logic [NUM_ENG-1:0]       eng_empty;
  logic [NUM_ENG-1:0]       eng_pop;
  logic [LIT_W-1:0]         uca_min;
  logic                     uca_valid;
  logic                     uca_pop;
  logic [LIT_W-1:0]         uca_out;
  logic                     uca_out_valid;
  logic                     uca_full;
  logic [NUM_ENG-1:0]       eng_out_full;
  logic [LIT_W-1:0]         bcast_uc;
  logic [NUM_ENG-1:0]       bcast_push;
  logic                     conflict_in;
  logic                     halt;
  logic [ID_W-1:0]          grant_id;

  modport master (
    input  eng_uc, eng_empty, uca_pop, uca_out, uca_out_valid, eng_out_full, conflict_in,
    output eng_pop, uca_min, uca_valid, uca_full, bcast_uc, bcast_push, halt, grant_id
  );

  modport slave (
    output eng_uc, eng_empty, uca_pop, uca_out, uca_out_valid, eng_out_full, conflict_in,
    input  eng_pop, uca_min, uca_valid, uca_full, bcast_uc, bcast_push, halt, grant_id
  );
endinterface

// File: rtl/ucq_rr_scheduler.sv
// Round-robin front end sharing one unit-clause arbiter between NUM_ENG engines.
// Request side: grant one non-empty UCQ_in, pop its head, hold it for the arbiter.
// Response side: 1-entry buffer broadcast to all UCQ_out in lock-step.
// Conflict halts everything until reset.
// Optional macro BCAST_DEDUP_EN: suppress broadcasting a literal equal to the last one pushed.
module ucq_rr_scheduler #(
  parameter int NUM_ENG = 4,
  parameter int LIT_W   = 8,
  parameter int ID_W    = $clog2(NUM_ENG)
) (
  input  logic               clk,
  input  logic               rst_n,
  ucq_rr_scheduler_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_HALT} state_t;

  state_t                         state;
  logic [ID_W-1:0]                rr_ptr;
  logic [ID_W-1:0]                grant_id;
  logic [LIT_W-1:0]               hold_lit;
  logic                           uca_valid;
  logic                           halt;
  logic                           buf_v;
  logic [LIT_W-1:0]               buf_lit;
  logic [NUM_ENG-1:0][LIT_W-1:0]  lit;

  logic                           req_any;
  logic [ID_W-1:0]                grant;
  logic [ID_W-1:0]                next_ptr;
  logic                           take;
  logic [NUM_ENG-1:0]             eng_pop;
  int                             scan_idx;
  logic [ID_W-1:0]                scan_cand;

  logic                           capture;
  logic                           drain;
  logic                           push;
  logic                           buf_clear;
  logic                           any_full;

  // Unpack the flat head-literal bus into one lane per engine.
  for (genvar g = 0; g < NUM_ENG; g++) begin : g_lane
    assign lit[g] = bus.eng_uc[g*LIT_W +: LIT_W];
  end

  // Round-robin search: first non-empty engine at or after rr_ptr, wrapping.
  // Scanning from the far end lets the nearest candidate overwrite earlier hits.
  always_comb begin
    req_any   = 1'b0;
    grant     = '0;
    scan_idx  = 0;
    scan_cand = '0;
    for (int k = NUM_ENG-1; k >= 0; k--) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_ENG) scan_idx = scan_idx - NUM_ENG;
      scan_cand = ID_W'(scan_idx);
      if (!bus.eng_empty[scan_cand]) begin
        req_any = 1'b1;
        grant   = scan_cand;
      end
    end
  end

  assign next_ptr = (grant == ID_W'(NUM_ENG-1)) ? '0 : grant + ID_W'(1);

  // A grant is taken only from idle, never in a conflict cycle, never in reset.
  assign take = rst_n && (state == S_IDLE) && req_any && !bus.conflict_in;

  // One-hot pop strobe, live only in the granting cycle.
  always_comb begin
    eng_pop = '0;
    if (take) eng_pop[grant] = 1'b1;
  end

  // Request FSM: idle -> hold until the arbiter pops; conflict is terminal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      hold_lit  <= '0;
      uca_valid <= 1'b0;
      halt      <= 1'b0;
    end else if (bus.conflict_in) begin
      state     <= S_HALT;
      halt      <= 1'b1;
      uca_valid <= 1'b0;
      hold_lit  <= '0;
    end else begin
      case (state)
        S_IDLE: if (take) begin
          hold_lit  <= lit[grant];
          grant_id  <= grant;
          rr_ptr    <= next_ptr;
          uca_valid <= 1'b1;
          state     <= S_HOLD;
        end
        S_HOLD: if (bus.uca_pop) begin
          uca_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: ;
      endcase
    end
  end

  // Broadcast buffer: capture only when empty, drain only when full,
  // so capture and drain never share a cycle.
  assign any_full = |bus.eng_out_full;
  assign capture  = bus.uca_out_valid && !buf_v && !halt && !bus.conflict_in;
  assign drain    = buf_v && !bus.conflict_in;

`ifdef BCAST_DEDUP_EN
  logic [LIT_W-1:0] last_bcast;
  logic             dup;

  // A repeat of the last pushed literal is dropped even if some engine is full.
  assign dup       = (buf_lit == last_bcast);
  assign push      = drain && !dup && !any_full;
  assign buf_clear = drain && (dup || !any_full);

  // Remember the last literal that actually reached the engines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_bcast <= '0;
    else if (push) last_bcast <= buf_lit;
  end
`else
  assign push      = drain && !any_full;
  assign buf_clear = push;
`endif

  // Buffer state; conflict flushes it, a valid while occupied is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_v   <= 1'b0;
      buf_lit <= '0;
    end else if (bus.conflict_in) begin
      buf_v   <= 1'b0;
    end else if (capture) begin
      buf_v   <= 1'b1;
      buf_lit <= bus.uca_out;
    end else if (buf_clear) begin
      buf_v   <= 1'b0;
    end
  end

  assign bus.eng_pop    = eng_pop;
  assign bus.uca_min    = hold_lit;
  assign bus.uca_valid  = uca_valid;
  assign bus.uca_full   = buf_v;
  assign bus.bcast_uc   = buf_lit;
  assign bus.bcast_push = {NUM_ENG{push}};
  assign bus.halt       = halt;
  assign bus.grant_id   = grant_id;

endmodule
